// File: rtl/alu_mul_sequencer_pkg.sv
// Shared definitions for the ALU/multiplier sequencer slice: ALU control
// codes (common to decoder, ALU and sequencer) and the sequencer state type.
package alu_mul_sequencer_pkg;

  localparam int ALU_W   = 32;
  localparam int ALU_SHW = 5;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCAN  = 3'd1,
    SHIFT = 3'd2,
    ADD   = 3'd3,
    DONE  = 3'd4
  } seq_state_e;

endpackage

// File: rtl/alu_mul_sequencer_if.sv
// Multiply request/response bundle between the execute stage (master) and
// the shift-and-add sequencer (slave).
interface alu_mul_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] product;

  modport master (
    output start, mul_a, mul_b,
    input  busy, done, product
  );

  modport slave (
    input  start, mul_a, mul_b,
    output busy, done, product
  );
endinterface

// File: rtl/alu_port_mux.sv
// Selects who drives the shared ALU: the datapath operands when the
// sequencer is not using it, the sequencer's operands when it is.
module alu_port_mux #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             owned,
  input  logic [WIDTH-1:0] dp_a,
  input  logic [WIDTH-1:0] dp_b,
  input  logic [3:0]       dp_control,
  input  logic [SHW-1:0]   dp_shamt,
  input  logic [WIDTH-1:0] seq_a,
  input  logic [WIDTH-1:0] seq_b,
  input  logic [3:0]       seq_control,
  input  logic [SHW-1:0]   seq_shamt,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_control,
  output logic [SHW-1:0]   alu_shamt
);

  // Pure combinational select; no state, so datapath sees no added latency.
  assign alu_a       = owned ? seq_a       : dp_a;
  assign alu_b       = owned ? seq_b       : dp_b;
  assign alu_control = owned ? seq_control : dp_control;
  assign alu_shamt   = owned ? seq_shamt   : dp_shamt;

endmodule

// File: rtl/alu_mul_sequencer.sv
// Multi-cycle unsigned multiplier that borrows the shared ALU, building the
// product from SLL and ADD operations (shift-and-add over mul_b's bits).
// Optional build macro: MUL_EARLY_TERM_EN -- finish as soon as no set bits
// of the multiplier remain, instead of scanning all WIDTH bits.
module alu_mul_sequencer
  import alu_mul_sequencer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic              clk,
  input  logic              reset,
  alu_mul_sequencer_if.slave bus,
  input  logic [WIDTH-1:0]  dp_a,
  input  logic [WIDTH-1:0]  dp_b,
  input  logic [3:0]        dp_control,
  input  logic [SHW-1:0]    dp_shamt,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [3:0]        alu_control,
  output logic [SHW-1:0]    alu_shamt,
  input  logic [WIDTH-1:0]  alu_result
);

  localparam logic [SHW-1:0] LAST_IDX = SHW'(WIDTH - 1);

  seq_state_e       state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplr;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] partial;
  logic [SHW-1:0]   idx;
  logic [SHW-1:0]   idx_next;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] product_q;

  logic             owned;
  logic [WIDTH-1:0] seq_a;
  logic [WIDTH-1:0] seq_b;
  logic [3:0]       seq_control;
  logic [SHW-1:0]   seq_shamt;

  assign idx_next    = idx + SHW'(1);
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;

  // The sequencer owns the ALU only while working; reset hands it back at once.
  assign owned = ((state == SCAN) || (state == SHIFT) || (state == ADD)) && !reset;

  // Operands the sequencer presents to the ALU in each working state.
  // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
  always_comb begin
    seq_a       = '0;
    seq_b       = '0;
    seq_control = ALU_AND;
    seq_shamt   = '0;
    case (state)
      SHIFT: begin
        seq_control = ALU_SLL;
        seq_b       = mcand;
        seq_shamt   = idx;
      end
      ADD: begin
        seq_control = ALU_ADD;
        seq_a       = acc;
        seq_b       = partial;
      end
      default: ;
    endcase
  end

  alu_port_mux #(
    .WIDTH(WIDTH),
    .SHW  (SHW)
  ) u_port_mux (
    .owned      (owned),
    .dp_a       (dp_a),
    .dp_b       (dp_b),
    .dp_control (dp_control),
    .dp_shamt   (dp_shamt),
    .seq_a      (seq_a),
    .seq_b      (seq_b),
    .seq_control(seq_control),
    .seq_shamt  (seq_shamt),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_control(alu_control),
    .alu_shamt  (alu_shamt)
  );

  // Shift-and-add FSM with registered busy/done/product.
  // NOTE: state is updated with non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mcand     <= '0;
      mplr      <= '0;
      acc       <= '0;
      partial   <= '0;
      idx       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            mcand  <= bus.mul_a;
            mplr   <= bus.mul_b;
            acc    <= '0;
            idx    <= '0;
            busy_q <= 1'b1;
            state  <= SCAN;
          end
        end

        SCAN: begin
`ifdef MUL_EARLY_TERM_EN
          if ((mplr >> idx) == '0) begin
            busy_q <= 1'b0;
            state  <= DONE;
          end else
`endif
          if (mplr[idx]) begin
            state <= SHIFT;
          end else if (idx == LAST_IDX) begin
            busy_q <= 1'b0;
            state  <= DONE;
          end else begin
            idx <= idx_next;
          end
        end

        SHIFT: begin
          partial <= alu_result;
          state   <= ADD;
        end

        ADD: begin
          acc <= alu_result;
          if (idx == LAST_IDX) begin
            busy_q <= 1'b0;
            state  <= DONE;
`ifdef MUL_EARLY_TERM_EN
          // Looking ahead here saves the extra SCAN visit after the last set bit.
          end else if ((mplr >> idx_next) == '0) begin
            busy_q <= 1'b0;
            state  <= DONE;
`endif
          end else begin
            idx   <= idx_next;
            state <= SCAN;
          end
        end

        DONE: begin
          product_q <= acc;
          done_q    <= 1'b1;
          state     <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer with a behavioural ALU attached.
module tb_alu_mul_sequencer;
  import alu_mul_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dp_a, dp_b;
  logic [3:0]  dp_control;
  logic [4:0]  dp_shamt;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_control;
  logic [4:0]  alu_shamt;
  logic        alu_zero;

  int n_cmp = 0;
  int n_bad = 0;
  int add_uses = 0;
  int done_pulses = 0;

  always #100 clk = ~clk;

  alu_mul_sequencer_if #(.WIDTH(32)) mbus ();

  alu_mul_sequencer #(.WIDTH(32), .SHW(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (mbus),
    .dp_a       (dp_a),
    .dp_b       (dp_b),
    .dp_control (dp_control),
    .dp_shamt   (dp_shamt),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_control(alu_control),
    .alu_shamt  (alu_shamt),
    .alu_result (alu_result)
  );

  // Behavioural model of the shared ALU.
  always_comb begin
    alu_result = '0;
    case (alu_control)
      ALU_AND: alu_result = alu_a & alu_b;
      ALU_OR:  alu_result = alu_a | alu_b;
      ALU_ADD: alu_result = alu_a + alu_b;
      ALU_SUB: alu_result = alu_a - alu_b;
      ALU_SLL: alu_result = alu_b << alu_shamt;
      ALU_SLT: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      ALU_NOR: alu_result = ~(alu_a | alu_b);
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  // Free-running monitors; tests take differences between snapshots.
  always @(negedge clk) begin
    if (mbus.busy && alu_control == ALU_ADD) add_uses <= add_uses + 1;
    if (mbus.done) done_pulses <= done_pulses + 1;
  end

  function automatic int popcount(input logic [31:0] v);
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(v[i]);
    return c;
  endfunction

  function automatic int exp_latency(input logic [31:0] b);
`ifdef MUL_EARLY_TERM_EN
    int hi = 0;
    if (b == 0) return 2;
    for (int i = 0; i < 32; i++) if (b[i]) hi = i;
    return 2 + 2 * popcount(b) + hi;
`else
    return 33 + 2 * popcount(b);
`endif
  endfunction

  // Starts a multiply and waits for done; optionally pulses a second start
  // (2*2) on cycle intrude_at, which must be ignored.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                         input int intrude_at,
                         output logic [31:0] prod, output int lat,
                         output int adds, output int pulses);
    int adds0, pulses0;
    @(negedge clk);
    adds0 = add_uses;
    pulses0 = done_pulses;
    mbus.start = 1'b1;
    mbus.mul_a = a;
    mbus.mul_b = b;
    @(posedge clk);
    lat = -1;
    prod = '0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      mbus.start = (k == intrude_at);
      if (k == intrude_at) begin
        mbus.mul_a = 32'd2;
        mbus.mul_b = 32'd2;
      end
      @(posedge clk);
      #1;
      if (mbus.done) begin
        lat = k;
        prod = mbus.product;
        break;
      end
    end
    mbus.start = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    adds = add_uses - adds0;
    pulses = done_pulses - pulses0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (mbus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", mbus.busy); end
    n_cmp++; if (mbus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", mbus.done); end
    n_cmp++; if (mbus.product !== 32'd0) begin n_bad++; $display("FAIL reset_product: got %h want 0", mbus.product); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_passthrough();
    @(negedge clk);
    dp_a = 32'd4; dp_b = 32'd1; dp_control = ALU_SUB; dp_shamt = 5'd0;
    #1;
    n_cmp++; if (alu_result !== 32'd3) begin n_bad++; $display("FAIL pass_sub: got %0d want 3", alu_result); end
    n_cmp++; if (alu_zero !== 1'b0) begin n_bad++; $display("FAIL pass_zero: got %b want 0", alu_zero); end
    dp_control = ALU_SLL; dp_shamt = 5'd3;
    #1;
    n_cmp++; if (alu_result !== 32'd8) begin n_bad++; $display("FAIL pass_sll: got %0d want 8", alu_result); end
    n_cmp++; if (alu_shamt !== 5'd3) begin n_bad++; $display("FAIL pass_shamt: got %0d want 3", alu_shamt); end
    dp_control = ALU_SUB; dp_shamt = 5'd0;
  endtask

  task automatic test_mul(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] want);
    logic [31:0] prod;
    int lat, adds, pulses;
    run_mul(a, b, 0, prod, lat, adds, pulses);
    n_cmp++; if (prod !== want) begin n_bad++; $display("FAIL %s_product: got %h want %h", name, prod, want); end
    n_cmp++; if (lat != exp_latency(b)) begin n_bad++; $display("FAIL %s_latency: got %0d want %0d", name, lat, exp_latency(b)); end
    // One ADD-state ALU use per set bit of the multiplier.
    n_cmp++; if (adds != popcount(b)) begin n_bad++; $display("FAIL %s_adds: got %0d want %0d", name, adds, popcount(b)); end
    n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL %s_pulses: got %0d want 1", name, pulses); end
    n_cmp++; if (mbus.product !== want) begin n_bad++; $display("FAIL %s_held: got %h want %h", name, mbus.product, want); end
  endtask

  task automatic test_reset_abort();
    int p0;
    @(negedge clk);
    mbus.start = 1'b1; mbus.mul_a = 32'd6; mbus.mul_b = 32'd7;
    @(posedge clk);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      mbus.start = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_cmp++; if (alu_control !== ALU_SUB) begin n_bad++; $display("FAIL abort_giveback: got %b want %b", alu_control, ALU_SUB); end
    @(posedge clk);
    #1;
    n_cmp++; if (mbus.busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", mbus.busy); end
    n_cmp++; if (mbus.done !== 1'b0) begin n_bad++; $display("FAIL abort_done: got %b want 0", mbus.done); end
    n_cmp++; if (mbus.product !== 32'd0) begin n_bad++; $display("FAIL abort_product: got %h want 0", mbus.product); end
    @(negedge clk);
    reset = 1'b0;
    p0 = done_pulses;
    repeat (60) @(negedge clk);
    #1;
    n_cmp++; if (done_pulses != p0) begin n_bad++; $display("FAIL abort_no_done: got %0d pulses want 0", done_pulses - p0); end
    test_mul("after_abort_3x3", 32'd3, 32'd3, 32'd9);
  endtask

  task automatic test_back_to_back();
    logic [31:0] prod;
    int lat, adds, pulses;
    run_mul(32'd6, 32'd7, 5, prod, lat, adds, pulses);
    n_cmp++; if (prod !== 32'd42) begin n_bad++; $display("FAIL b2b_product: got %0d want 42", prod); end
    n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL b2b_pulses: got %0d want 1", pulses); end
    n_cmp++; if (lat != exp_latency(32'd7)) begin n_bad++; $display("FAIL b2b_latency: got %0d want %0d", lat, exp_latency(32'd7)); end
    repeat (5) @(negedge clk);
    n_cmp++; if (mbus.product !== 32'd42) begin n_bad++; $display("FAIL b2b_held: got %0d want 42", mbus.product); end
    n_cmp++; if (mbus.busy !== 1'b0) begin n_bad++; $display("FAIL b2b_idle: got %b want 0", mbus.busy); end
  endtask

  initial begin
    reset = 1'b1;
    mbus.start = 1'b0;
    mbus.mul_a = '0;
    mbus.mul_b = '0;
    dp_a = '0; dp_b = '0; dp_control = ALU_SUB; dp_shamt = '0;
    test_reset();
    test_passthrough();
    test_mul("mul_6x7", 32'd6, 32'd7, 32'd42);
    test_reset_abort();
    test_mul("mul_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    test_mul("mul_by_zero", 32'd5, 32'd0, 32'd0);
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
